stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz; it sets the 1 Hz prescaler terminal count.
REQ-002 Parameter DB_CYCLES, default 1000000, number of consecutive stable samples for a button to be accepted.
REQ-003 Port clk, input, 1, sole clock; all state is rising-edge clocked.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port btnP, input, 1, raw pause button, asynchronous to clk, bouncing.
REQ-006 Port btnR, input, 1, raw clear button, asynchronous to clk, bouncing.
REQ-007 Port swADJ, input, 1, raw adjust-mode switch.
REQ-008 Port swSEL, input, 1, raw adjust select (1 = seconds, 0 = minutes).
REQ-009 Port cnt_en, output, 1, one-cycle pulse; the counter advances by 1 s.
REQ-010 Port adj_en, output, 1, one-cycle pulse; the counter increments the selected field.
REQ-011 Port adj_sel, output, 1, synchronized swSEL.
REQ-012 Port clr, output, 1, one-cycle pulse; the counter zeroes minutes and seconds.
REQ-013 Port paused, output, 1, level; 1 while the run flag is clear.
REQ-014 Port blink, output, 1, display blink enable (see Configuration).

Function
REQ-015 Each of btnP, btnR, swADJ and swSEL SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Each button SHALL be debounced: the filtered level changes only after DB_CYCLES consecutive equal synchronized samples.
REQ-017 Each filtered button SHALL produce a press pulse one cycle wide on its 0->1 edge only; release produces no pulse.
REQ-018 The prescaler SHALL count 0..CLK_HZ-1 and wrap; tick1 pulses when count == CLK_HZ-1; tick2 pulses when count == CLK_HZ/2-1 or CLK_HZ-1.
REQ-019 The FSM SHALL have states PAUSED, RUN, ADJ and CLEAR, plus a 1-bit run flag.
REQ-020 From any state, a btnR pulse SHALL enter CLEAR for exactly one cycle, then PAUSED; CLEAR asserts clr, zeroes the run flag and the prescaler.
REQ-021 In PAUSED, a btnP pulse SHALL set the run flag and enter RUN; in RUN, a btnP pulse SHALL clear the run flag and enter PAUSED.
REQ-022 In PAUSED or RUN with synchronized swADJ=1, the FSM SHALL enter ADJ; in ADJ, a btnP pulse toggles the run flag.
REQ-023 In ADJ with swADJ=0, the FSM SHALL enter RUN if the run flag is 1, else PAUSED.
REQ-024 Priority SHALL be btnR > swADJ > btnP when they coincide in the same cycle.
REQ-025 cnt_en SHALL equal tick1 AND state==RUN; adj_en SHALL equal tick2 AND state==ADJ AND run flag; both are registered, with 1-cycle latency from the tick.
REQ-026 cnt_en, adj_en and clr SHALL be mutually exclusive in every cycle.

Reset
REQ-027 While rst_n=0: state PAUSED; run flag, prescaler, synchronizers and debouncers at 0; cnt_en=0, adj_en=0, clr=0, adj_sel=0, paused=1, blink=1.
REQ-028 Deassertion of rst_n SHALL be synchronized internally; the first post-reset prescaler count SHALL be 0.

Configuration
REQ-029 Macro STOPWATCH_BLINK_EN, when defined: in ADJ, blink toggles on every tick2 (1 Hz square wave); outside ADJ, blink=1.
REQ-030 Without STOPWATCH_BLINK_EN, blink SHALL be tied to 1 and the toggle flop SHALL not exist.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state encoding (PAUSED=2'd0, RUN=2'd1, ADJ=2'd2, CLEAR=2'd3) and the default CLK_HZ/DB_CYCLES constants.
REQ-032 Sub-module debouncer (sync + stable counter + press pulse) SHALL be instantiated twice; the prescaler and FSM stay in the top level.

Verification (CLK_HZ=8, DB_CYCLES=3)
REQ-033 Reset, then btnP held for 5 cycles -> one btnP pulse; RUN; cnt_en every 8 cycles; paused=0.
REQ-034 btnP toggled with 2-cycle glitches -> no pulse; state unchanged.
REQ-035 In RUN, swADJ=1 with swSEL=1 -> ADJ; adj_en every 4 cycles; adj_sel=1; cnt_en stays 0; swADJ=0 returns to RUN.
REQ-036 btnR and btnP presses land in the same cycle while in RUN -> clr=1 for one cycle; then PAUSED, paused=1, prescaler restarts from 0.
REQ-037 In ADJ, a btnP pulse -> adj_en stops; swADJ=0 -> PAUSED.
REQ-038 With STOPWATCH_BLINK_EN in ADJ -> blink period 8 cycles; without the macro -> blink constantly 1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJ    = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_DB_CYCLES = 1_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debouncer.sv
// Button conditioner: 2-flop synchronizer, stable-sample filter and a
// one-cycle press pulse on the filtered 0->1 edge.
module debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // cnt_q counts consecutive synchronized samples that disagree with level_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            press_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    press_q <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, 1 Hz / 2 Hz prescaler and the
// PAUSED/RUN/ADJ/CLEAR sequencer. Optional blink toggle: STOPWATCH_BLINK_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnP,
    input  logic btnR,
    input  logic swADJ,
    input  logic swSEL,
    output logic cnt_en,
    output logic adj_en,
    output logic adj_sel,
    output logic clr,
    output logic paused,
    output logic blink
);

    localparam int unsigned PW = cnt_width(CLK_HZ);

    logic [1:0]    rst_sync_q;
    logic          rst_int;
    logic          p_press;
    logic          r_press;
    logic [1:0]    adj_sync_q;
    logic [1:0]    sel_sync_q;
    logic [PW-1:0] presc_q;
    logic          tick1;
    logic          tick2;
    state_t        state_q;
    state_t        state_d;
    logic          run_q;
    logic          run_d;
    logic          cnt_en_q;
    logic          adj_en_q;
    logic          clr_q;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int = rst_sync_q[1];

    debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_p (
        .clk   (clk),
        .rst_n (rst_int),
        .raw   (btnP),
        .press (p_press)
    );

    debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk   (clk),
        .rst_n (rst_int),
        .raw   (btnR),
        .press (r_press)
    );

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            adj_sync_q <= '0;
            sel_sync_q <= '0;
        end else begin
            adj_sync_q <= {adj_sync_q[0], swADJ};
            sel_sync_q <= {sel_sync_q[0], swSEL};
        end
    end

    assign tick1 = (presc_q == PW'(CLK_HZ - 1));
    assign tick2 = tick1 || (presc_q == PW'(CLK_HZ / 2 - 1));

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            presc_q <= '0;
        end else if (state_q == CLEAR || tick1) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state_q <= PAUSED;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (r_press) begin
            state_d = CLEAR;
            run_d   = 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    state_d = PAUSED;
                    run_d   = 1'b0;
                end
                PAUSED: begin
                    if (adj_sync_q[1]) begin
                        state_d = ADJ;
                    end else if (p_press) begin
                        state_d = RUN;
                        run_d   = 1'b1;
                    end
                end
                RUN: begin
                    if (adj_sync_q[1]) begin
                        state_d = ADJ;
                    end else if (p_press) begin
                        state_d = PAUSED;
                        run_d   = 1'b0;
                    end
                end
                ADJ: begin
                    if (!adj_sync_q[1]) begin
                        state_d = run_q ? RUN : PAUSED;
                    end else if (p_press) begin
                        run_d = ~run_q;
                    end
                end
                default: begin
                    state_d = PAUSED;
                    run_d   = 1'b0;
                end
            endcase
        end
    end

    // clr is registered from state_d so it is high exactly while state_q is
    // CLEAR; enables are dropped on the entry edge to keep all three exclusive.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            cnt_en_q <= 1'b0;
            adj_en_q <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            cnt_en_q <= tick1 && (state_q == RUN) && (state_d != CLEAR);
            adj_en_q <= tick2 && (state_q == ADJ) && run_q && (state_d != CLEAR);
            clr_q    <= (state_d == CLEAR);
        end
    end

    assign cnt_en  = cnt_en_q;
    assign adj_en  = adj_en_q;
    assign clr     = clr_q;
    assign adj_sel = sel_sync_q[1];
    assign paused  = ~run_q;

`ifdef STOPWATCH_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            blink_q <= 1'b1;
        end else if (state_q != ADJ) begin
            blink_q <= 1'b1;
        end else if (tick2) begin
            blink_q <= ~blink_q;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=8, DB_CYCLES=3.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic btnP, btnR, swADJ, swSEL;
    logic cnt_en, adj_en, adj_sel, clr, paused, blink;

    int checks   = 0;
    int failures = 0;
    int p_pulses = 0;
    int excl_viol = 0;

    stopwatch_ctrl #(.CLK_HZ(8), .DB_CYCLES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btnP    (btnP),
        .btnR    (btnR),
        .swADJ   (swADJ),
        .swSEL   (swSEL),
        .cnt_en  (cnt_en),
        .adj_en  (adj_en),
        .adj_sel (adj_sel),
        .clr     (clr),
        .paused  (paused),
        .blink   (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.p_press === 1'b1) p_pulses++;

    always @(negedge clk)
        if (rst_n === 1'b1 && (int'(cnt_en) + int'(adj_en) + int'(clr)) > 1) excl_viol++;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cnt_en;
            1:       return adj_en;
            default: return clr;
        endcase
    endfunction

    // Cycles between two consecutive pulses; -1 when the first never comes.
    task automatic period(input int sel, input string tag, input int exp);
        int n = 0;
        int meas;
        while (sig(sel) !== 1'b1 && n < 40) begin step(1); n++; end
        if (sig(sel) === 1'b1) begin
            n = 0;
            do begin step(1); n++; end while (sig(sel) !== 1'b1 && n < 40);
            meas = n;
        end else begin
            meas = -1;
        end
        chk(tag, meas, exp);
    endtask

    task automatic count_pulses(input int sel, input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            if (sig(sel) === 1'b1) c++;
        end
    endtask

    task automatic press_p();
        btnP = 1'b1; step(5);
        btnP = 1'b0; step(6);
    endtask

    initial begin
        int c, n, toggles, p_before;
        logic prev;
        rst_n = 1'b0; btnP = 1'b0; btnR = 1'b0; swADJ = 1'b0; swSEL = 1'b0;
        step(3);
        chk("rst_cnt_en",  int'(cnt_en),  0);
        chk("rst_adj_en",  int'(adj_en),  0);
        chk("rst_clr",     int'(clr),     0);
        chk("rst_adj_sel", int'(adj_sel), 0);
        chk("rst_paused",  int'(paused),  1);
        chk("rst_blink",   int'(blink),   1);

        rst_n = 1'b1;
        step(4);
        chk("post_rst_state", int'(dut.state_q), int'(PAUSED));

        // Clean press: exactly one pulse, RUN, 1 s enable every 8 cycles.
        press_p();
        chk("press_pulses", p_pulses, 1);
        chk("press_state",  int'(dut.state_q), int'(RUN));
        chk("press_paused", int'(paused), 0);
        period(0, "cnt_en_period", 8);
        period(0, "cnt_en_period2", 8);

        // 2-cycle glitches never qualify.
        p_before = p_pulses;
        for (int g = 0; g < 3; g++) begin
            btnP = 1'b1; step(2);
            btnP = 1'b0; step(2);
        end
        step(6);
        chk("glitch_pulses", p_pulses, p_before);
        chk("glitch_state",  int'(dut.state_q), int'(RUN));

        // Adjust seconds while running.
        swSEL = 1'b1; swADJ = 1'b1;
        step(4);
        chk("adj_state",   int'(dut.state_q), int'(ADJ));
        chk("adj_sel_sec", int'(adj_sel), 1);
        period(1, "adj_en_period", 4);
        count_pulses(0, 16, c);
        chk("adj_no_cnt_en", c, 0);
        toggles = 0;
        for (int i = 0; i < 32; i++) begin
            prev = blink; step(1);
            if (blink !== prev) toggles++;
        end
`ifdef STOPWATCH_BLINK_EN
        chk("blink_toggles", toggles, 8);
`else
        chk("blink_toggles", toggles, 0);
        chk("blink_tied", int'(blink), 1);
`endif
        swADJ = 1'b0;
        step(4);
        chk("adj_exit_run", int'(dut.state_q), int'(RUN));
        chk("run_blink",    int'(blink), 1);
        chk("run_paused",   int'(paused), 0);

        // Clear and pause pressed together: clear wins.
        p_before = p_pulses;
        btnR = 1'b1; btnP = 1'b1;
        n = 0;
        while (clr !== 1'b1 && n < 40) begin step(1); n++; end
        chk("clr_seen",    int'(clr), 1);
        chk("clr_state",   int'(dut.state_q), int'(CLEAR));
        step(1);
        chk("clr_width",   int'(clr), 0);
        chk("clr_to_paused", int'(dut.state_q), int'(PAUSED));
        chk("clr_paused",  int'(paused), 1);
        chk("clr_presc0",  int'(dut.presc_q), 0);
        chk("clr_p_coincident", p_pulses, p_before + 1);
        btnR = 1'b0; btnP = 1'b0;
        count_pulses(0, 16, c);
        chk("paused_no_cnt_en", c, 0);
        chk("release_state", int'(dut.state_q), int'(PAUSED));

        // Adjust minutes, then pause from inside ADJ.
        press_p();
        chk("rerun_state", int'(dut.state_q), int'(RUN));
        swSEL = 1'b0; swADJ = 1'b1;
        step(4);
        chk("adj2_state",  int'(dut.state_q), int'(ADJ));
        chk("adj_sel_min", int'(adj_sel), 0);
        period(1, "adj2_en_period", 4);
        press_p();
        chk("adj_pause_paused", int'(paused), 1);
        chk("adj_pause_state",  int'(dut.state_q), int'(ADJ));
        count_pulses(1, 16, c);
        chk("adj_en_stopped", c, 0);
        swADJ = 1'b0;
        step(4);
        chk("adj_exit_paused", int'(dut.state_q), int'(PAUSED));

        chk("exclusive_outputs", excl_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
